// File: rtl/chip8_pkg.sv
// Shared constants and the draw-engine state encoding for the CHIP-8 datapath.
package chip8_pkg;

    localparam int SCREEN_W         = 64;
    localparam int SCREEN_H         = 32;
    localparam int SPRITE_MAX_BYTES = 15;
    localparam int COL_W            = $clog2(SCREEN_W);
    localparam int ROW_W            = $clog2(SCREEN_H);
    localparam int MEM_DATA_W       = 8 * SPRITE_MAX_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DRAW,
        ST_CLEAR,
        ST_DONE
    } draw_state_t;

endpackage

// File: rtl/sprite_row_shifter.sv
// Places one sprite byte on a framebuffer row starting at column x.
// Pixels that fall past the right edge are dropped; there is no wrap.
module sprite_row_shifter
    import chip8_pkg::*;
(
    input  logic [7:0]          sprite_byte,
    input  logic [COL_W-1:0]    x,
    output logic [SCREEN_W-1:0] mask
);

    // Bit 7 of the byte is the leftmost pixel, which lands on column x (bit 63-x).
    assign mask = {sprite_byte, {(SCREEN_W-8){1'b0}}} >> x;

endmodule

// File: rtl/sprite_draw_engine.sv
// CHIP-8 DXYN / 00E0 engine: fetches sprite bytes over the MMU multi-byte read
// port, XORs them into a 64x32 framebuffer one row per cycle, and reports VF.
module sprite_draw_engine
    import chip8_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  draw_start,
    input  logic                  clear_start,
    input  logic [7:0]            x_coord,
    input  logic [7:0]            y_coord,
    input  logic [3:0]            n_rows,
    input  logic [11:0]           i_addr,
    output logic                  mem_req,
    output logic [11:0]           mem_addr,
    output logic [3:0]            mem_len,
    input  logic [MEM_DATA_W-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  collision,
    input  logic [ROW_W-1:0]      disp_row_sel,
    output logic [SCREEN_W-1:0]   disp_row_data
);

    draw_state_t state;
    draw_state_t state_next;

    logic [COL_W-1:0]    x_lat;
    logic [ROW_W-1:0]    y_lat;
    logic [3:0]          n_lat;
    logic [11:0]         i_lat;
    logic [ROW_W-1:0]    row_ctr;
    logic [7:0]          sprite_buf [SPRITE_MAX_BYTES];
    logic [SCREEN_W-1:0] fb [SCREEN_H];

    logic                  draw_accept;
    logic [ROW_W:0]        draw_row;
    logic                  row_clipped;
    logic [SCREEN_W-1:0]   row_mask;
    logic                  row_hit;
    logic [6:0]            align_shift;
    logic [MEM_DATA_W-1:0] fetch_aligned;

    assign draw_accept = (state == ST_IDLE) && draw_start && !clear_start;

    // Target row may run past the bottom edge; the extra MSB flags that case.
    assign draw_row    = {1'b0, y_lat} + {1'b0, row_ctr};
    assign row_clipped = draw_row[ROW_W];
    assign row_hit     = |(fb[draw_row[ROW_W-1:0]] & row_mask);

    // Byte k sits N-k bytes up from bit 0; left-justifying makes byte k a constant slice.
    assign align_shift   = {4'd15 - n_lat, 3'b000};
    assign fetch_aligned = mem_data << align_shift;

    sprite_row_shifter u_shifter (
        .sprite_byte (sprite_buf[row_ctr[3:0]]),
        .x           (x_lat),
        .mask        (row_mask)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; clear wins over draw when both pulse together.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (clear_start)     state_next = ST_CLEAR;
                else if (draw_start) state_next = (n_rows == 4'd0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_DRAW;
            ST_DRAW: begin
                if ((row_ctr + 5'd1) == {1'b0, n_lat}) state_next = ST_DONE;
            end
            ST_CLEAR: begin
                if (row_ctr == ROW_W'(SCREEN_H - 1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign mem_req  = (state == ST_FETCH);
    assign mem_addr = mem_req ? i_lat : 12'h000;
    assign mem_len  = mem_req ? n_lat : 4'h0;

    // Operand latches, sprite buffer, row counter and collision flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_lat     <= '0;
            y_lat     <= '0;
            n_lat     <= '0;
            i_lat     <= '0;
            row_ctr   <= '0;
            collision <= 1'b0;
            for (int k = 0; k < SPRITE_MAX_BYTES; k++) sprite_buf[k] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    row_ctr <= '0;
                    if (draw_accept) begin
                        x_lat     <= COL_W'(x_coord % 8'(SCREEN_W));
                        y_lat     <= ROW_W'(y_coord % 8'(SCREEN_H));
                        n_lat     <= n_rows;
                        i_lat     <= i_addr;
                        collision <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    row_ctr <= '0;
                    for (int k = 0; k < SPRITE_MAX_BYTES; k++)
                        sprite_buf[k] <= fetch_aligned[MEM_DATA_W-1-8*k -: 8];
                end
                ST_DRAW: begin
                    row_ctr <= row_ctr + 5'd1;
                    if (!row_clipped && row_hit) collision <= 1'b1;
                end
                ST_CLEAR: row_ctr <= row_ctr + 5'd1;
                default:  row_ctr <= '0;
            endcase
        end
    end

    // Framebuffer: XOR one sprite row per DRAW cycle, zero one row per CLEAR cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this array is deliberately reset; the display must show a blank screen after rst.
        if (rst) begin
            for (int r = 0; r < SCREEN_H; r++) fb[r] <= '0;
        end else if (state == ST_DRAW && !row_clipped) begin
            fb[draw_row[ROW_W-1:0]] <= fb[draw_row[ROW_W-1:0]] ^ row_mask;
        end else if (state == ST_CLEAR) begin
            fb[row_ctr] <= '0;
        end
    end

    assign disp_row_data = fb[disp_row_sel];

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed self-checking bench for sprite_draw_engine with a one-cycle MMU model.
module tb_sprite_draw_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         draw_start;
    logic         clear_start;
    logic [7:0]   x_coord;
    logic [7:0]   y_coord;
    logic [3:0]   n_rows;
    logic [11:0]  i_addr;
    logic         mem_req;
    logic [11:0]  mem_addr;
    logic [3:0]   mem_len;
    logic [119:0] mem_data;
    logic         busy;
    logic         done;
    logic         collision;
    logic [4:0]   disp_row_sel;
    logic [63:0]  disp_row_data;

    logic [7:0]   mem [4096];
    logic [63:0]  exp_fb [32];

    int n_checks = 0;
    int n_fail   = 0;
    int last_reqs;
    logic [11:0] last_addr;
    logic [3:0]  last_len;

    sprite_draw_engine dut (
        .clk           (clk),
        .rst           (rst),
        .draw_start    (draw_start),
        .clear_start   (clear_start),
        .x_coord       (x_coord),
        .y_coord       (y_coord),
        .n_rows        (n_rows),
        .i_addr        (i_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_len       (mem_len),
        .mem_data      (mem_data),
        .busy          (busy),
        .done          (done),
        .collision     (collision),
        .disp_row_sel  (disp_row_sel),
        .disp_row_data (disp_row_data)
    );

    always #5 clk = ~clk;

    // MMU read port: byte k of the read lands at bits [8*(len-k)-1 -: 8].
    function automatic logic [119:0] mmu_read(input logic [11:0] a, input logic [3:0] len);
        logic [119:0] r;
        r = '0;
        for (int k = 0; k < int'(len); k++)
            r[8*(int'(len)-k)-1 -: 8] = mem[a + 12'(k)];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_req) mem_data <= mmu_read(mem_addr, mem_len);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rows(input string tag);
        for (int r = 0; r < 32; r++) begin
            disp_row_sel = 5'(r);
            #1;
            check($sformatf("%s_row%0d", tag, r), disp_row_data, exp_fb[r]);
        end
    endtask

    // Called #1 after the accepting edge (edge 0); counts edges until done is seen.
    task automatic wait_done(input string tag, input int exp_edges, input int poke_at);
        int edges = 0;
        int reqs  = 0;
        last_addr = '0;
        last_len  = '0;
        while (!done && edges < 200) begin
            if (mem_req) begin
                reqs++;
                last_addr = mem_addr;
                last_len  = mem_len;
            end
            draw_start = (edges == poke_at);
            @(posedge clk); #1;
            edges++;
        end
        draw_start = 1'b0;
        last_reqs  = reqs;
        check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_idle_done"}, {63'b0, done}, 64'd0);
    endtask

    task automatic start_draw(input logic [7:0] x, input logic [7:0] y,
                              input logic [3:0] n, input logic [11:0] i);
        x_coord = x; y_coord = y; n_rows = n; i_addr = i;
        draw_start = 1'b1;
        @(posedge clk); #1;
        draw_start = 1'b0;
    endtask

    task automatic start_clear();
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
    endtask

    task automatic zero_exp();
        for (int r = 0; r < 32; r++) exp_fb[r] = '0;
    endtask

    initial begin
        int done_seen;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'h100] = 8'hFF; mem[12'h101] = 8'hFF;
        mem[12'h200] = 8'h80;
        mem_data = '0;
        rst = 1'b1; draw_start = 1'b0; clear_start = 1'b0;
        x_coord = '0; y_coord = '0; n_rows = '0; i_addr = '0; disp_row_sel = '0;
        zero_exp();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_coll", {63'b0, collision}, 64'd0);
        check("rst_req",  {63'b0, mem_req}, 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_len",  64'(mem_len), 64'd0);
        check_rows("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: clear, then font '0' at (0,0)
        start_clear();
        wait_done("clr1", 32, -1);
        start_draw(8'd0, 8'd0, 4'd5, 12'h050);
        wait_done("font", 7, -1);
        check("font_reqs", 64'(last_reqs), 64'd1);
        check("font_addr", 64'(last_addr), 64'h050);
        check("font_len",  64'(last_len), 64'd5);
        check("font_coll", {63'b0, collision}, 64'd0);
        exp_fb[0] = 64'hF000_0000_0000_0000;
        exp_fb[1] = 64'h9000_0000_0000_0000;
        exp_fb[2] = 64'h9000_0000_0000_0000;
        exp_fb[3] = 64'h9000_0000_0000_0000;
        exp_fb[4] = 64'hF000_0000_0000_0000;
        check_rows("font");

        // 2: same draw erases and collides
        start_draw(8'd0, 8'd0, 4'd5, 12'h050);
        wait_done("erase", 7, -1);
        check("erase_coll", {63'b0, collision}, 64'd1);
        zero_exp();
        check_rows("erase");

        // 3: bottom-right corner, right and bottom clipping
        start_draw(8'd62, 8'd31, 4'd2, 12'h100);
        wait_done("corner", 4, -1);
        check("corner_coll", {63'b0, collision}, 64'd0);
        exp_fb[31] = 64'h0000_0000_0000_0003;
        check_rows("corner");

        // 4: coordinates wrap to column 6, row 3
        start_draw(8'd70, 8'd35, 4'd1, 12'h200);
        wait_done("wrap", 3, -1);
        check("wrap_coll", {63'b0, collision}, 64'd0);
        exp_fb[3] = 64'h0200_0000_0000_0000;
        check_rows("wrap");

        // Redraw to raise collision before the N==0 case
        start_draw(8'd70, 8'd35, 4'd1, 12'h200);
        wait_done("wrap2", 3, -1);
        check("wrap2_coll", {63'b0, collision}, 64'd1);
        exp_fb[3] = '0;

        // 5: N==0 finishes immediately, no fetch, collision cleared
        start_draw(8'd5, 8'd5, 4'd0, 12'h050);
        wait_done("n0", 0, -1);
        check("n0_reqs", 64'(last_reqs), 64'd0);
        check("n0_coll", {63'b0, collision}, 64'd0);
        check_rows("n0");

        // 6: clear wins over simultaneous draw; a draw pulse while busy is dropped
        x_coord = 8'd0; y_coord = 8'd0; n_rows = 4'd1; i_addr = 12'h200;
        draw_start = 1'b1; clear_start = 1'b1;
        @(posedge clk); #1;
        draw_start = 1'b0; clear_start = 1'b0;
        wait_done("both", 32, 3);
        check("both_reqs", 64'(last_reqs), 64'd0);
        zero_exp();
        check_rows("both");
        repeat (3) @(posedge clk);
        #1;
        check("both_noqueue_busy", {63'b0, busy}, 64'd0);

        // Reset in the middle of DRAW
        start_draw(8'd0, 8'd0, 4'd5, 12'h050);
        repeat (4) @(posedge clk);
        #1;
        disp_row_sel = 5'd0;
        #1;
        check("mid_row0", disp_row_data, 64'hF000_0000_0000_0000);
        check("mid_busy", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_done", {63'b0, done}, 64'd0);
        check_rows("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("mid_rst_nodone", 64'(done_seen), 64'd0);
        check("mid_rst_idle", {63'b0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
